keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans the 4x4 hardware keypad and produces the `key_coord` code that `input_unit` consumes. The code uses the format `{row_val, col_val}`, both active-low one-cold. The block drives the column lines one at a time, synchronises and debounces the row lines, and emits exactly one single-cycle code per physical key press. It sits between the board keypad pins and `input_unit`. It is the producer end of the `key_coord` interface.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1000: cycles a column is driven before rows are sampled (10 us at 100 MHz).
- `DEBOUNCE_CYCLES`, default 2_000_000: consecutive stable cycles required for both press and release (20 ms).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset. One clock domain only; polarity and synchronicity are fixed.
- `row_in`  in  4  keypad rows.
  - Asynchronous to `clk`, externally pulled up.
  - Low means a key in the driven column is closed.
- `col_out`  out  4  keypad column drive, one-cold. The low bit selects the column.
- `key_coord`  out  8  `{row_val, col_val}`.
  - Both halves are active-low one-cold. Example: key "1" = 8'b1110_1110.
  - Value is 8'h00 when no event is present.
  - Valid for exactly one cycle per press.

## Operation
- `row_in` passes through a 2-flop synchroniser. All decisions use the synchronised value `rows_s`.
- State `SCAN`:
  - `col_out` = one-cold pattern for `col_idx`, with 0 mapped to 4'b1110 and 3 mapped to 4'b0111.
  - The settle counter runs 0 to `SETTLE_CYCLES-1`.
  - On the last settle cycle, if `rows_s` is exactly one-cold: latch `row_l` = `rows_s` and `col_l` = `col_out`, clear the debounce counter, and go to `CONFIRM`.
  - Otherwise (all-ones, or two or more rows low): `col_idx` advances with wrap 3 to 0, the settle counter clears, and the state stays `SCAN`.
- State `CONFIRM`:
  - The column stays driven.
  - If `rows_s` != `row_l`, go to `SCAN` with `col_idx`+1 (the press is rejected as a bounce).
  - If they match and the counter is `DEBOUNCE_CYCLES-1`, go to `EMIT`. Otherwise the counter increments.
- State `EMIT`: lasts one cycle, then goes to `RELEASE`. The counter clears.
- State `RELEASE`:
  - The column stays driven.
  - Any `rows_s` != 4'hF clears the counter.
  - When `rows_s` == 4'hF and the counter is `DEBOUNCE_CYCLES-1`, go to `SCAN` with `col_idx`+1 and clear the settle counter.
- `key_coord` is registered: it equals `{row_l, col_l}` during the `EMIT` cycle and 8'h00 in every other cycle.
- Simultaneous keys:
  - Two keys in one column are ignored.
  - Keys in different columns: the first column scanned wins.
  - Other keys pressed during `RELEASE` produce nothing until the held key is released, then they are picked up on the normal scan.
- A key held indefinitely produces one event only. There is no auto-repeat.
- Counter widths are `$clog2` of the parameter, with a minimum of 1. Counters never wrap, because comparisons stop them at terminal count.

## Timing
- Reset values:
  - state `SCAN`, `col_idx` 0, `col_out` 4'b1110;
  - `key_coord` 8'h00;
  - both counters 0, `row_l` and `col_l` 4'hF;
  - synchroniser flops 4'hF.
- Reset mid-press: the block returns to the reset values immediately. Any pending event is dropped; `key_coord` is never asserted during or on exit from reset.
- Full scan period with no key pressed: 4 x `SETTLE_CYCLES` cycles.
- Press latency: `key_coord` is asserted exactly `DEBOUNCE_CYCLES` cycles after the first `CONFIRM` cycle. Add 2 synchroniser cycles plus up to one full scan period from the pin edge.
- Minimum spacing between events: `DEBOUNCE_CYCLES` + `DEBOUNCE_CYCLES` + `SETTLE_CYCLES` + 1 cycles.
- `input_unit` samples on `posedge clk`. A single-cycle pulse is sufficient, and no handshake or back-pressure exists.

## Structure
- Keypad code constants (`ZERO`..`NINE`, `BACKSPACE`, `ENTER`, `PAUSE`, `TOGGLE`, `C`, `D`, and `KEY_NONE` = 8'h00) move into `definitions.v` as shared defines. Both `input_unit` and this block use them.
- State encoding (`SCAN`, `CONFIRM`, `EMIT`, `RELEASE`) stays local.
- One sub-module: `sync_2ff`, a parameterised-width 2-flop synchroniser with a reset value input. It is reusable for the switch inputs.

## Test plan
Use `SETTLE_CYCLES`=4 and `DEBOUNCE_CYCLES`=8 for all scenarios.
1. Reset then idle for 100 cycles:
   - `col_out` cycles 1110, 1101, 1011, 0111 with 4 cycles per column;
   - `key_coord` stays 00.
2. Model key "5" (row 1, col 1), held for 40 cycles:
   - exactly one pulse `key_coord` = 8'b1101_1101;
   - the pulse arrives 8 cycles after `CONFIRM` entry;
   - no further pulse while held.
3. Bounce: "#" closes for 3 cycles, opens for 2, then holds stable → one 8'b0111_1011 pulse, only after a full stable window of 8 cycles.
4. Rows 0 and 2 both low in column 0 → no pulse. Scanning continues.
5. Hold "A", press "1" during `RELEASE`, release "A" → pulse 1110_0111, then after "A" has stayed released for 8 cycles a pulse 1110_1110.
6. Assert `rst_n` low during `CONFIRM` →
   - immediate `col_out` 1110 and `key_coord` 00;
   - after release, a still-held key yields a fresh full-latency event.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, key codes and
// small helpers for one-cold row/column patterns.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    EMIT    = 2'd2,
    RELEASE = 2'd3
  } scan_state_e;

  // Codes are {row_val, col_val}, both active-low one-cold.
  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] ONE       = 8'b1110_1110;
  localparam logic [7:0] TWO       = 8'b1110_1101;
  localparam logic [7:0] THREE     = 8'b1110_1011;
  localparam logic [7:0] PAUSE     = 8'b1110_0111;
  localparam logic [7:0] FOUR      = 8'b1101_1110;
  localparam logic [7:0] FIVE      = 8'b1101_1101;
  localparam logic [7:0] SIX       = 8'b1101_1011;
  localparam logic [7:0] TOGGLE    = 8'b1101_0111;
  localparam logic [7:0] SEVEN     = 8'b1011_1110;
  localparam logic [7:0] EIGHT     = 8'b1011_1101;
  localparam logic [7:0] NINE      = 8'b1011_1011;
  localparam logic [7:0] C         = 8'b1011_0111;
  localparam logic [7:0] BACKSPACE = 8'b0111_1110;
  localparam logic [7:0] ZERO      = 8'b0111_1101;
  localparam logic [7:0] ENTER     = 8'b0111_1011;
  localparam logic [7:0] D         = 8'b0111_0111;

  function automatic logic isOneCold(input logic [3:0] v);
    return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
  endfunction

  function automatic logic [3:0] colDrive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; the reset value is a
// port so pulled-up lines can come out of reset in their idle state.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_rst_val,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= i_rst_val;
      r_sync <= i_rst_val;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: drives columns one-cold, debounces the synchronised rows
// and emits one single-cycle {row, col} code per key press.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 1000,
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [7:0] key_coord
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DEB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [DEB_W-1:0]    DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]          w_rows_s;
  scan_state_e         r_state;
  scan_state_e         w_state_next;
  logic [1:0]          r_col_idx;
  logic [SETTLE_W-1:0] r_settle_cnt;
  logic [DEB_W-1:0]    r_deb_cnt;
  logic [3:0]          r_row_l;
  logic [3:0]          r_col_l;
  logic [7:0]          r_key_coord;
  logic [7:0]          w_key_next;

  logic w_settle_done;
  logic w_deb_done;
  logic w_one_cold;
  logic w_row_match;
  logic w_rows_idle;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rst_val (4'hF),
    .i_d       (row_in),
    .o_q       (w_rows_s)
  );

  assign w_settle_done = (r_settle_cnt == SETTLE_LAST);
  assign w_deb_done    = (r_deb_cnt == DEB_LAST);
  assign w_one_cold    = isOneCold(w_rows_s);
  assign w_row_match   = (w_rows_s == r_row_l);
  assign w_rows_idle   = (w_rows_s == 4'hF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SCAN;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SCAN:    if (w_settle_done && w_one_cold) w_state_next = CONFIRM;
      CONFIRM: begin
        if (!w_row_match)    w_state_next = SCAN;
        else if (w_deb_done) w_state_next = EMIT;
      end
      EMIT:    w_state_next = RELEASE;
      RELEASE: if (w_rows_idle && w_deb_done) w_state_next = SCAN;
      default: w_state_next = SCAN;
    endcase
  end

  // key_coord is registered from the next state so it is high exactly in EMIT.
  always_comb begin
    col_out    = colDrive(r_col_idx);
    w_key_next = (w_state_next == EMIT) ? {r_row_l, r_col_l} : KEY_NONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_idx    <= 2'd0;
      r_settle_cnt <= '0;
      r_deb_cnt    <= '0;
      r_row_l      <= 4'hF;
      r_col_l      <= 4'hF;
      r_key_coord  <= KEY_NONE;
    end else begin
      r_key_coord <= w_key_next;
      case (r_state)
        SCAN: begin
          if (w_settle_done) begin
            r_settle_cnt <= '0;
            if (w_one_cold) begin
              r_row_l   <= w_rows_s;
              r_col_l   <= col_out;
              r_deb_cnt <= '0;
            end else begin
              r_col_idx <= r_col_idx + 2'd1;
            end
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        CONFIRM: begin
          if (!w_row_match)    r_col_idx <= r_col_idx + 2'd1;
          else if (!w_deb_done) r_deb_cnt <= r_deb_cnt + 1'b1;
        end
        EMIT: r_deb_cnt <= '0;
        RELEASE: begin
          if (!w_rows_idle) begin
            r_deb_cnt <= '0;
          end else if (w_deb_done) begin
            r_col_idx    <= r_col_idx + 2'd1;
            r_settle_cnt <= '0;
          end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign key_coord = r_key_coord;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SETTLE_CYCLES=4, DEBOUNCE_CYCLES=8,
// using a switch-matrix model of the keypad driving row_in from col_out.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [7:0] key_coord;
  logic [15:0] keys = 16'h0000;

  int checks = 0;
  int errors = 0;

  keypad_scanner #(.SETTLE_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_coord (key_coord)
  );

  always #5 clk = ~clk;

  // A closed switch at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic checkOutput(input string tag, input int n, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, n, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic closed);
    keys[idx] = closed;
  endtask

  function automatic logic [3:0] colPattern(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (idx % 4));
  endfunction

  // Holds reset for a few cycles, checks reset outputs, releases on a negedge.
  task automatic resetDut();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_col", 0, {4'h0, col_out}, 8'h0E);
    checkOutput("reset_key", 0, key_coord, 8'h00);
    rst_n = 1'b1;
  endtask

  initial begin
    $display("[TB] keypad_scanner directed test start");

    // 1: idle scanning
    keys = 16'h0000;
    resetDut();
    for (int n = 0; n < 100; n++) begin
      checkOutput("idle_col", n, {4'h0, col_out}, {4'h0, colPattern(n / 4)});
      checkOutput("idle_key", n, key_coord, 8'h00);
      @(negedge clk);
    end

    // 2: key "5" held 40 cycles; CONFIRM entered at cycle 8, pulse at 16
    keys = 16'h0000;
    applyStimulus(5, 1'b1);
    resetDut();
    for (int n = 0; n <= 60; n++) begin
      checkOutput("five_key", n, key_coord, (n == 16) ? 8'b1101_1101 : 8'h00);
      if (n >= 4 && n <= 49) checkOutput("five_col_hold", n, {4'h0, col_out}, 8'h0D);
      if (n == 50) checkOutput("five_col_next", n, {4'h0, col_out}, 8'h0B);
      if (n == 40) applyStimulus(5, 1'b0);
      @(negedge clk);
    end

    // 3: "#" bounce (closed 8..10, open 11..12, closed from 13); pulse at 38
    keys = 16'h0000;
    resetDut();
    for (int n = 0; n <= 60; n++) begin
      checkOutput("bounce_key", n, key_coord, (n == 38) ? 8'b0111_1011 : 8'h00);
      applyStimulus(14, (n >= 8 && n <= 10) || (n >= 13));
      @(negedge clk);
    end
    applyStimulus(14, 1'b0);

    // 4: "1" and "7" both closed in column 0 are ignored
    keys = 16'h0000;
    applyStimulus(0, 1'b1);
    applyStimulus(8, 1'b1);
    resetDut();
    for (int n = 0; n < 40; n++) begin
      checkOutput("dual_col", n, {4'h0, col_out}, {4'h0, colPattern(n / 4)});
      checkOutput("dual_key", n, key_coord, 8'h00);
      @(negedge clk);
    end

    // 5: hold "A", press "1" during RELEASE, release "A" at 30
    keys = 16'h0000;
    applyStimulus(3, 1'b1);
    resetDut();
    for (int n = 0; n <= 70; n++) begin
      checkOutput("rollover_key", n, key_coord,
                  (n == 24) ? 8'b1110_0111 : (n == 52) ? 8'b1110_1110 : 8'h00);
      if (n == 26) applyStimulus(0, 1'b1);
      if (n == 30) applyStimulus(3, 1'b0);
      @(negedge clk);
    end

    // 6: reset asserted mid-CONFIRM while "5" stays held
    keys = 16'h0000;
    applyStimulus(5, 1'b1);
    resetDut();
    for (int n = 0; n <= 10; n++) begin
      checkOutput("rst_pre_key", n, key_coord, 8'h00);
      if (n == 10) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rst_now_col", n, {4'h0, col_out}, 8'h0E);
        checkOutput("rst_now_key", n, key_coord, 8'h00);
      end
      @(negedge clk);
    end
    for (int n = 0; n < 3; n++) begin
      checkOutput("rst_hold_col", n, {4'h0, col_out}, 8'h0E);
      checkOutput("rst_hold_key", n, key_coord, 8'h00);
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int n = 0; n <= 30; n++) begin
      checkOutput("rst_after_key", n, key_coord, (n == 16) ? 8'b1101_1101 : 8'h00);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
